// File: rtl/demux1x2_tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux1x2_tdm_pkg
// Brief    : Shared FSM state encoding and channel tags for demux1x2_tdm.
// Revision : 1.0
// ============================================================================
package demux1x2_tdm_pkg;

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        WAIT1 = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic CH_I0 = 1'b0;
    localparam logic CH_I1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/demux1x2_tdm_pair_counter.sv
`default_nettype none
// ============================================================================
// Module   : pair_counter
// Brief    : Free-wrapping CNT_W-bit event counter with enable.
// Revision : 1.0
// ============================================================================
module pair_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/demux1x2_tdm.sv
`default_nettype none
// ============================================================================
// Module   : demux1x2_tdm
// Brief    : Rebuilds (I0, I1) sample pairs from a 2:1 time-multiplexed stream.
// Revision : 1.0
// ============================================================================
module demux1x2_tdm
    import demux1x2_tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] ch0_out,
    output logic [WIDTH-1:0] ch1_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             seq_err,
    output logic [CNT_W-1:0] pair_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic             w_din_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_load0;
    logic             w_load1;
    logic             w_err;
    logic [WIDTH-1:0] r_ch0;
    logic [WIDTH-1:0] r_ch1;
    logic             r_seq_err;

    assign w_accept = din_valid && w_din_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT0;
        end else begin
            r_state <= w_next;
        end
    end

    // An accept in HOLD is only possible while the pair is being taken,
    // so a good I0 there starts the next pair without a bubble.
    always_comb begin
        w_next  = r_state;
        w_load0 = 1'b0;
        w_load1 = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            WAIT0: begin
                if (w_accept) begin
                    if (sel == CH_I0) begin
                        w_load0 = 1'b1;
                        w_next  = WAIT1;
                    end else begin
                        w_err   = 1'b1;
                    end
                end
            end
            WAIT1: begin
                if (w_accept) begin
                    if (sel == CH_I1) begin
                        w_load1 = 1'b1;
                        w_next  = HOLD;
                    end else begin
                        w_load0 = 1'b1;
                        w_err   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_next = WAIT0;
                    if (w_accept) begin
                        if (sel == CH_I0) begin
                            w_load0 = 1'b1;
                            w_next  = WAIT1;
                        end else begin
                            w_err   = 1'b1;
                        end
                    end
                end
            end
            default: w_next = WAIT0;
        endcase
    end

    always_comb begin
        w_din_ready = 1'b1;
        w_out_valid = 1'b0;
        if (r_state == HOLD) begin
            w_din_ready = out_ready;
            w_out_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch0     <= '0;
            r_ch1     <= '0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_load0) begin
                r_ch0 <= din;
            end
            if (w_load1) begin
                r_ch1 <= din;
            end
            r_seq_err <= w_err;
        end
    end

    pair_counter #(
        .CNT_W (CNT_W)
    ) u_pair_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_out_valid && out_ready),
        .o_cnt (pair_cnt)
    );

    assign din_ready = w_din_ready;
    assign out_valid = w_out_valid;
    assign ch0_out   = r_ch0;
    assign ch1_out   = r_ch1;
    assign seq_err   = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_demux1x2_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1x2_tdm
// Brief    : Directed self-checking bench for demux1x2_tdm (CNT_W = 4).
// Revision : 1.0
// ============================================================================
module tb_demux1x2_tdm;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             sel;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] ch0_out;
    logic [WIDTH-1:0] ch1_out;
    logic             out_valid;
    logic             out_ready;
    logic             seq_err;
    logic [CNT_W-1:0] pair_cnt;

    int n_total;
    int n_bad;
    int exp_cnt;

    demux1x2_tdm #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ch0_out   (ch0_out),
        .ch1_out   (ch1_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .seq_err   (seq_err),
        .pair_cnt  (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic s, input logic [WIDTH-1:0] d);
        din_valid = 1'b1;
        sel       = s;
        din       = d;
        step();
        din_valid = 1'b0;
    endtask

    // Full pair with out_ready=1: check HOLD contents, then the handshake.
    task automatic deliver(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        out_ready = 1'b1;
        accept(1'b0, a);
        accept(1'b1, b);
        chk("dl_valid", 32'(out_valid), 32'd1);
        chk("dl_ch0", 32'(ch0_out), 32'(a));
        chk("dl_ch1", 32'(ch1_out), 32'(b));
        step();
        exp_cnt = (exp_cnt + 1) % 16;
        chk("dl_cnt", 32'(pair_cnt), 32'(exp_cnt));
        chk("dl_valid_lo", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag, input int dummy);
        chk({tag, "_ch0"}, 32'(ch0_out), 32'd0);
        chk({tag, "_ch1"}, 32'(ch1_out), 32'd0);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_seqerr"}, 32'(seq_err), 32'd0);
        chk({tag, "_cnt"}, 32'(pair_cnt), 32'd0);
        chk({tag, "_dready"}, 32'(din_ready), 32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        exp_cnt   = 0;
        rst_n     = 1'b1;
        din       = '0;
        sel       = 1'b0;
        din_valid = 1'b0;
        out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("rst", 0);
        repeat (2) @(posedge clk);
        release_reset();

        // basic pair
        out_ready = 1'b1;
        accept(1'b0, 8'hA5);
        chk("b_valid_w1", 32'(out_valid), 32'd0);
        accept(1'b1, 8'h3C);
        chk("b_valid", 32'(out_valid), 32'd1);
        chk("b_ch0", 32'(ch0_out), 32'hA5);
        chk("b_ch1", 32'(ch1_out), 32'h3C);
        chk("b_cnt0", 32'(pair_cnt), 32'd0);
        step();
        exp_cnt = 1;
        chk("b_cnt1", 32'(pair_cnt), 32'd1);

        // backpressure in HOLD
        out_ready = 1'b0;
        accept(1'b0, 8'h55);
        accept(1'b1, 8'h66);
        din_valid = 1'b1;
        sel       = 1'b0;
        din       = 8'h77;
        #1;
        chk("bp_dready", 32'(din_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ch0", 32'(ch0_out), 32'h55);
            chk("bp_ch1", 32'(ch1_out), 32'h66);
            chk("bp_cnt", 32'(pair_cnt), 32'd1);
        end
        out_ready = 1'b1;
        din       = 8'h11;
        #1;
        chk("bp_dready_hi", 32'(din_ready), 32'd1);
        step();
        din_valid = 1'b0;
        exp_cnt = 2;
        chk("bp_cnt2", 32'(pair_cnt), 32'd2);
        chk("bp_valid_lo", 32'(out_valid), 32'd0);
        chk("bp_ch0_new", 32'(ch0_out), 32'h11);
        chk("bp_ch1_keep", 32'(ch1_out), 32'h66);
        accept(1'b1, 8'h22);
        chk("bp_w1_valid", 32'(out_valid), 32'd1);
        chk("bp_w1_ch0", 32'(ch0_out), 32'h11);
        chk("bp_w1_ch1", 32'(ch1_out), 32'h22);
        step();
        exp_cnt = 3;
        chk("bp_cnt3", 32'(pair_cnt), 32'd3);

        // out-of-order samples
        accept(1'b1, 8'h99);
        chk("oo_err1", 32'(seq_err), 32'd1);
        chk("oo_valid", 32'(out_valid), 32'd0);
        chk("oo_ch1_keep", 32'(ch1_out), 32'h22);
        step();
        chk("oo_err1_lo", 32'(seq_err), 32'd0);
        accept(1'b0, 8'h01);
        chk("oo_err_none", 32'(seq_err), 32'd0);
        accept(1'b0, 8'h02);
        chk("oo_err2", 32'(seq_err), 32'd1);
        chk("oo_ch0_resync", 32'(ch0_out), 32'h02);
        accept(1'b1, 8'h03);
        chk("oo_err2_lo", 32'(seq_err), 32'd0);
        chk("oo_valid_pair", 32'(out_valid), 32'd1);
        chk("oo_ch0", 32'(ch0_out), 32'h02);
        chk("oo_ch1", 32'(ch1_out), 32'h03);
        step();
        exp_cnt = 4;
        chk("oo_cnt", 32'(pair_cnt), 32'd4);

        // I1 arriving in HOLD while the pair is taken
        accept(1'b0, 8'h44);
        accept(1'b1, 8'h45);
        accept(1'b1, 8'h46);
        exp_cnt = 5;
        chk("h1_err", 32'(seq_err), 32'd1);
        chk("h1_valid", 32'(out_valid), 32'd0);
        chk("h1_cnt", 32'(pair_cnt), 32'd5);
        chk("h1_ch1", 32'(ch1_out), 32'h45);
        chk("h1_ch0", 32'(ch0_out), 32'h44);

        // async reset while in WAIT1
        accept(1'b0, 8'h7E);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rw1", 0);
        exp_cnt = 0;
        release_reset();
        deliver(8'h12, 8'h34);

        // async reset while in HOLD with out_ready low
        out_ready = 1'b0;
        accept(1'b0, 8'h56);
        accept(1'b1, 8'h78);
        chk("rh_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rh", 0);
        exp_cnt = 0;
        release_reset();
        deliver(8'h9A, 8'hBC);

        // counter wrap from a fresh reset: 17 pairs
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        release_reset();
        for (int i = 0; i < 17; i++) begin
            deliver(8'(i), 8'(8'hF0 - i));
        end
        chk("wrap_final", 32'(pair_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
